alu_issue_sched: RTL

//  Shares the single 16-bit LC-3b ALU between two requesters: A = execute stage, B = address/agen unit.

---
 rtl/alu_issue_sched_pkg.sv | 26 ++
 rtl/alu_issue_sched_alu.sv | 38 +++
 rtl/alu_issue_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_issue_sched_pkg.sv
// Shared constants and types for the ALU issue scheduler and its ALU.
package alu_issue_sched_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_OP_W   = 3;
  localparam int unsigned DEF_SH_W   = 4;

  // Requester tags carried alongside each op through the pipeline.
  localparam logic TAG_A = 1'b0;
  localparam logic TAG_B = 1'b1;

  // Condition codes come out of reset as Z set.
  localparam logic [2:0] CC_RESET = 3'b010;

  typedef enum logic [2:0] {
    OpAdd   = 3'b000,
    OpAnd   = 3'b001,
    OpXor   = 3'b010,
    OpNot   = 3'b011,
    OpLshf  = 3'b100,
    OpRshfl = 3'b101,
    OpRshfa = 3'b110,
    OpPass  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_issue_sched_alu.sv
// Combinational LC-3b ALU: arithmetic/logic ops plus shifts of in1, with sign flags.
module alu
  import alu_issue_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OP_W   = DEF_OP_W,
  parameter int unsigned SH_W   = DEF_SH_W
) (
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [OP_W-1:0]   op,
  input  logic [SH_W-1:0]   shift,
  output logic [DATA_W-1:0] out,
  output logic              zero,
  output logic              positive,
  output logic              negative
);

  // Opcode decode and result flags.
  always_comb begin
    out = '0;
    case (op)
      OpAdd:   out = in1 + in2;
      OpAnd:   out = in1 & in2;
      OpXor:   out = in1 ^ in2;
      OpNot:   out = ~in1;
      OpLshf:  out = in1 << shift;
      OpRshfl: out = in1 >> shift;
      OpRshfa: out = DATA_W'($signed(in1) >>> shift);
      OpPass:  out = in2;
      default: out = '0;
    endcase
    negative = out[DATA_W-1];
    zero     = (out == '0);
    positive = !negative && !zero;
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Two-requester round-robin issue to a shared ALU, with operand (S1) and
// result (S2) pipeline registers and the architectural NZP register.
module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OP_W   = DEF_OP_W,
  parameter int unsigned SH_W   = DEF_SH_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [DATA_W-1:0] a_in1,
  input  logic [DATA_W-1:0] a_in2,
  input  logic [OP_W-1:0]   a_op,
  input  logic [SH_W-1:0]   a_shift,
  input  logic              a_set_cc,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [DATA_W-1:0] b_in1,
  input  logic [DATA_W-1:0] b_in2,
  input  logic [OP_W-1:0]   b_op,
  input  logic [SH_W-1:0]   b_shift,
  input  logic              b_set_cc,
  output logic              a_rsp_valid,
  input  logic              a_rsp_ready,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [2:0]        rsp_nzp,
  output logic [2:0]        cc_nzp,
  output logic              idle
);

  logic              s1_valid_q, s1_tag_q, s1_set_cc_q;
  logic [DATA_W-1:0] s1_in1_q, s1_in2_q;
  logic [OP_W-1:0]   s1_op_q;
  logic [SH_W-1:0]   s1_shift_q;

  logic              s2_valid_q, s2_tag_q, s2_set_cc_q;
  logic [DATA_W-1:0] s2_result_q;
  logic [2:0]        s2_nzp_q;

  logic              last_grant_q;
  logic [2:0]        cc_q;

  logic              s2_free, s1_adv, can_take, req_any, grant, accept, s2_consume;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero, alu_pos, alu_neg;

  // Pipeline flow control and round-robin grant.
  always_comb begin
    s2_consume  = s2_valid_q && ((s2_tag_q == TAG_A) ? a_rsp_ready : b_rsp_ready);
    s2_free     = !s2_valid_q || s2_consume;
    s1_adv      = s1_valid_q && s2_free;
    can_take    = !s1_valid_q || s1_adv;
    req_any     = a_req_valid || b_req_valid;
    if (a_req_valid && b_req_valid) grant = ~last_grant_q;
    else if (a_req_valid)           grant = TAG_A;
    else                            grant = TAG_B;
    // With no request pending both sides see ready; once any request is up
    // only the granted one does.
    a_req_ready = can_take && (!req_any || grant == TAG_A);
    b_req_ready = can_take && (!req_any || grant == TAG_B);
    accept      = can_take && req_any;
  end

  // Operand stage: capture the granted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= TAG_A;
      s1_set_cc_q  <= 1'b0;
      s1_in1_q     <= '0;
      s1_in2_q     <= '0;
      s1_op_q      <= '0;
      s1_shift_q   <= '0;
      last_grant_q <= TAG_B;
    end else if (accept) begin
      s1_valid_q   <= 1'b1;
      s1_tag_q     <= grant;
      last_grant_q <= grant;
      s1_set_cc_q  <= (grant == TAG_A) ? a_set_cc : b_set_cc;
      s1_in1_q     <= (grant == TAG_A) ? a_in1    : b_in1;
      s1_in2_q     <= (grant == TAG_A) ? a_in2    : b_in2;
      s1_op_q      <= (grant == TAG_A) ? a_op     : b_op;
      s1_shift_q   <= (grant == TAG_A) ? a_shift  : b_shift;
    end else if (s1_adv) begin
      s1_valid_q   <= 1'b0;
    end
  end

  alu #(
    .DATA_W(DATA_W),
    .OP_W  (OP_W),
    .SH_W  (SH_W)
  ) u_alu (
    .in1     (s1_in1_q),
    .in2     (s1_in2_q),
    .op      (s1_op_q),
    .shift   (s1_shift_q),
    .out     (alu_out),
    .zero    (alu_zero),
    .positive(alu_pos),
    .negative(alu_neg)
  );

  // Result stage and condition codes; result held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q  <= 1'b0;
      s2_tag_q    <= TAG_A;
      s2_set_cc_q <= 1'b0;
      s2_result_q <= '0;
      s2_nzp_q    <= '0;
      cc_q        <= CC_RESET;
    end else if (s1_adv) begin
      s2_valid_q  <= 1'b1;
      s2_tag_q    <= s1_tag_q;
      s2_set_cc_q <= s1_set_cc_q;
      s2_result_q <= alu_out;
      s2_nzp_q    <= {alu_neg, alu_zero, alu_pos};
      if (s1_set_cc_q) cc_q <= {alu_neg, alu_zero, alu_pos};
    end else if (s2_consume) begin
      s2_valid_q  <= 1'b0;
    end
  end

  // Response steering and status.
  always_comb begin
    a_rsp_valid = s2_valid_q && (s2_tag_q == TAG_A);
    b_rsp_valid = s2_valid_q && (s2_tag_q == TAG_B);
    rsp_result  = s2_result_q;
    rsp_nzp     = s2_nzp_q;
    cc_nzp      = cc_q;
    idle        = !s1_valid_q && !s2_valid_q;
  end

endmodule
